wb_stage: RTL

//   Write-back stage: the producer end of the register-file write port (WB_en/WB_addr/WB_data)

---
 rtl/wb_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Write-back stage: accepts MEM results, waits for load data, formats loads and issues one
// registered register-file write per instruction; counts retired instructions.
module wb_stage #(
   parameter int unsigned LOAD_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_RegWrite,
   input  logic        in_MemtoReg,
   input  logic [4:0]  in_Rd,
   input  logic [2:0]  in_Funct3,
   input  logic [31:0] in_ALUResult,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        WB_en,
   output logic [4:0]  WB_addr,
   output logic [31:0] WB_data,
   output logic [31:0] retire_count,
   output logic        load_timeout
);

   typedef enum logic {IDLE, WAIT_LOAD} state_t;

   state_t      state, state_nxt;
   logic        ld_regwrite;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_ofs;
   logic [31:0] tmo_cnt;
   logic        xfer;
   logic        tmo_hit;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign xfer    = in_valid & in_ready;
   // Abort on the wait cycle whose increment would bring the counter to the limit.
   assign tmo_hit = (LOAD_TIMEOUT != 0) && ((tmo_cnt + 32'd1) == LOAD_TIMEOUT);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (xfer && in_MemtoReg) state_nxt = WAIT_LOAD;
         WAIT_LOAD: if (dmem_rvalid || tmo_hit) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = rst && (state == IDLE);
   end

   always_comb begin
      ld_byte = dmem_rdata[8*ld_ofs +: 8];
      ld_half = ld_ofs[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (ld_funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         WB_en        <= 1'b0;
         WB_addr      <= 5'd0;
         WB_data      <= 32'd0;
         retire_count <= 32'd0;
         load_timeout <= 1'b0;
         tmo_cnt      <= 32'd0;
         ld_regwrite  <= 1'b0;
         ld_rd        <= 5'd0;
         ld_funct3    <= 3'd0;
         ld_ofs       <= 2'd0;
      end else begin
         WB_en <= 1'b0;
         case (state)
            IDLE: begin
               if (xfer && !in_MemtoReg) begin
                  // Address/data only move on a real write so they hold while WB_en is low.
                  if (in_RegWrite && (in_Rd != 5'd0)) begin
                     WB_en   <= 1'b1;
                     WB_addr <= in_Rd;
                     WB_data <= in_ALUResult;
                  end
                  retire_count <= retire_count + 32'd1;
               end else if (xfer) begin
                  ld_regwrite <= in_RegWrite;
                  ld_rd       <= in_Rd;
                  ld_funct3   <= in_Funct3;
                  ld_ofs      <= in_ALUResult[1:0];
                  tmo_cnt     <= 32'd0;
               end
            end
            WAIT_LOAD: begin
               if (dmem_rvalid) begin
                  if (ld_regwrite && (ld_rd != 5'd0)) begin
                     WB_en   <= 1'b1;
                     WB_addr <= ld_rd;
                     WB_data <= ld_data;
                  end
                  retire_count <= retire_count + 32'd1;
               end else if (tmo_hit) begin
                  load_timeout <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
